// File: rtl/store_pack_unit.sv
// Store path: narrows a GPR value to byte/half/word, lane-aligns it onto the 32-bit memory bus
// with little-endian byte enables, and queues legal stores in a small FIFO toward data memory.
module store_pack_unit #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_size,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   output logic          misalign,
   output logic [AW-1:0] err_addr,
   output logic          empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [BW-1:0] be_q   [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          legal_c;
   logic          accept_c;
   logic          push_c;
   logic          pop_c;
   logic [DW-1:0] pack_data_c;
   logic [BW-1:0] pack_be_c;
   logic [AW-1:0] word_addr_c;
   logic [CW-1:0] count_next_c;
   logic [PW-1:0] rd_next_ptr_c;
   logic [AW-1:0] head_addr_c;
   logic [DW-1:0] head_data_c;
   logic [BW-1:0] head_be_c;

   // Size/offset legality and lane packing; disabled lanes carry replicated data
   always_comb begin
      legal_c     = 1'b0;
      pack_be_c   = '0;
      pack_data_c = req_wdata;
      case (req_size)
         2'b00: begin
            legal_c     = 1'b1;
            pack_be_c   = BW'(4'b0001 << req_addr[1:0]);
            pack_data_c = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            legal_c     = ~req_addr[0];
            pack_be_c   = req_addr[1] ? 4'b1100 : 4'b0011;
            pack_data_c = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            legal_c     = (req_addr[1:0] == 2'b00);
            pack_be_c   = 4'b1111;
            pack_data_c = req_wdata;
         end
         default: begin
            legal_c = 1'b0;
         end
      endcase
   end

   assign word_addr_c   = {req_addr[AW-1:2], 2'b00};
   assign accept_c      = req_valid & req_ready;
   assign push_c        = accept_c & legal_c;
   assign pop_c         = mem_valid & mem_ready;
   assign count_next_c  = count + CW'(push_c) - CW'(pop_c);
   assign rd_next_ptr_c = rd_ptr + PW'(1);

   // Next head register: following entry on a pop, or the incoming store when it becomes head
   always_comb begin
      head_addr_c = mem_addr;
      head_data_c = mem_wdata;
      head_be_c   = mem_be;
      if (pop_c) begin
         if (count >= CW'(2)) begin
            head_addr_c = addr_q[rd_next_ptr_c];
            head_data_c = data_q[rd_next_ptr_c];
            head_be_c   = be_q[rd_next_ptr_c];
         end else if (push_c) begin
            head_addr_c = word_addr_c;
            head_data_c = pack_data_c;
            head_be_c   = pack_be_c;
         end
      end else if ((count == '0) && push_c) begin
         head_addr_c = word_addr_c;
         head_data_c = pack_data_c;
         head_be_c   = pack_be_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         req_ready <= 1'b1;
         mem_valid <= 1'b0;
         empty     <= 1'b1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         misalign  <= 1'b0;
         err_addr  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_next_ptr_c;
         count     <= count_next_c;
         req_ready <= (count_next_c != CW'(DEPTH));
         mem_valid <= (count_next_c != '0);
         empty     <= (count_next_c == '0);
         mem_addr  <= head_addr_c;
         mem_wdata <= head_data_c;
         mem_be    <= head_be_c;
         misalign  <= accept_c & ~legal_c;
         if (accept_c && !legal_c) err_addr <= req_addr;
      end
   end

   // Entry storage; contents are only meaningful behind a valid count
   always_ff @(posedge clk) begin
      if (push_c) begin
         addr_q[wr_ptr] <= word_addr_c;
         data_q[wr_ptr] <= pack_data_c;
         be_q[wr_ptr]   <= pack_be_c;
      end
   end

endmodule

// File: tb/tb_store_pack_unit.sv
// Bench for store_pack_unit: directed scenarios plus random traffic against a queue-based model.
module tb_store_pack_unit;

   localparam int DEPTH = 2;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          misalign;
   logic [AW-1:0] err_addr;
   logic          empty;

   store_pack_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .misalign(misalign), .err_addr(err_addr), .empty(empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ent_t;

   ent_t        q[$];
   logic        exp_mis;
   logic [31:0] exp_err;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [1:0] size, input logic [31:0] addr);
      int nbytes;
      if (size == 2'b11) return 1'b0;
      nbytes = 1 << size;
      return (addr % nbytes) == 0;
   endfunction

   // Byte lane i is enabled when it falls inside [offset, offset+nbytes); its data is wdata byte i mod nbytes
   function automatic ent_t pack(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
      ent_t e;
      int   nbytes, off;
      nbytes = 1 << size;
      off    = addr % 4;
      e.addr = addr - off;
      e.be   = '0;
      e.data = '0;
      for (int i = 0; i < 4; i++) begin
         e.be[i] = (i >= off) && (i < off + nbytes);
         e.data[8*i +: 8] = wd[8*(i % nbytes) +: 8];
      end
      return e;
   endfunction

   task automatic check_all();
      chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
      chk("misalign", 32'(misalign), 32'(exp_mis));
      chk("err_addr", err_addr, exp_err);
      if (q.size() != 0) begin
         chk("mem_addr", mem_addr, q[0].addr);
         chk("mem_wdata", mem_wdata, q[0].data);
         chk("mem_be", 32'(mem_be), 32'(q[0].be));
      end
   endtask

   // One clock: model transition from the inputs held across the edge, then compare
   task automatic cycle();
      bit   hs, leg, pop;
      ent_t e;
      hs  = req_valid && (q.size() < DEPTH);
      leg = is_legal(req_size, req_addr);
      pop = (q.size() > 0) && mem_ready;
      e   = pack(req_size, req_addr, req_wdata);
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      if (hs && leg) q.push_back(e);
      exp_mis = hs && !leg;
      if (exp_mis) exp_err = req_addr;
      check_all();
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      req_valid = v;
      req_size  = s;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic drain();
      drive(1'b0, 2'b10, 32'h0, 32'h0);
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
   endtask

   initial begin
      rst = 1'b1;
      mem_ready = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      exp_mis = 1'b0;
      exp_err = '0;
      #1;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
      #11 rst = 1'b0;

      // SB to the top lane
      mem_ready = 1'b1;
      drive(1'b1, 2'b00, 32'h1003, 32'hAABBCCDD);
      cycle();
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      chk("sb_addr", mem_addr, 32'h1000);
      chk("sb_be", 32'(mem_be), 32'h8);
      chk("sb_data", mem_wdata, 32'hDDDDDDDD);
      cycle();

      // SH upper half, then misaligned SH
      drive(1'b1, 2'b01, 32'h2002, 32'h12345678);
      cycle();
      chk("sh_be", 32'(mem_be), 32'hC);
      chk("sh_data", mem_wdata, 32'h56785678);
      drive(1'b1, 2'b01, 32'h2001, 32'h12345678);
      cycle();
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      chk("sh_mis_pulse", 32'(misalign), 32'd1);
      chk("sh_mis_err", err_addr, 32'h2001);
      cycle();
      chk("sh_mis_once", 32'(misalign), 32'd0);
      drain();

      // Back-pressure: three SW into a two-entry FIFO
      mem_ready = 1'b0;
      drive(1'b1, 2'b10, 32'h10, 32'h11111111);
      cycle();
      drive(1'b1, 2'b10, 32'h14, 32'h22222222);
      cycle();
      drive(1'b1, 2'b10, 32'h18, 32'h33333333);
      cycle();
      chk("full_ready", 32'(req_ready), 32'd0);
      cycle();
      mem_ready = 1'b1;
      cycle();
      chk("full_dq_ready", 32'(req_ready), 32'd1);
      cycle();
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      cycle();
      cycle();
      drain();

      // Steady count 1 with push+pop every edge across pointer wrap
      mem_ready = 1'b0;
      drive(1'b1, 2'b10, 32'h100, $urandom);
      cycle();
      mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'b10, 32'h104 + 32'(4 * i), $urandom);
         cycle();
         chk("wrap_count1", 32'(mem_valid && req_ready), 32'd1);
      end
      drain();

      // Illegal size, then two illegal requests back to back
      drive(1'b1, 2'b11, 32'h0, 32'h5);
      cycle();
      chk("sz11_pulse", 32'(misalign), 32'd1);
      drive(1'b1, 2'b10, 32'h302, 32'h5);
      cycle();
      drive(1'b1, 2'b11, 32'h404, 32'h5);
      cycle();
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      chk("b2b_pulse", 32'(misalign), 32'd1);
      chk("b2b_err", err_addr, 32'h404);
      cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom & 32'hFFFF, $urandom);
         mem_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      // Asynchronous reset while full
      mem_ready = 1'b0;
      drive(1'b1, 2'b10, 32'h500, 32'hCAFEF00D);
      cycle();
      drive(1'b1, 2'b00, 32'h505, 32'h77);
      cycle();
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      chk("pre_rst_valid", 32'(mem_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      q.delete();
      exp_mis = 1'b0;
      exp_err = '0;
      chk("arst_mem_valid", 32'(mem_valid), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      chk("arst_mem_be", 32'(mem_be), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
